// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds the combinational instruction memory and fills IF/ID.
// Interrupt trap entry / mret return are built only when FETCH_IRQ_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        in_rst,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instr,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_irq,
  input  logic        i_mret,
  output logic        o_irq_ack,
  output logic [31:0] o_mepc,
  output logic [31:0] o_ifid_pc,
  output logic [31:0] o_ifid_instr,
  output logic        o_ifid_valid
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic        w_mret_take;
  logic        w_irq_take;
  logic [31:0] w_pc_nxt;
  logic        w_flush;
  logic        w_hold;

`ifdef FETCH_IRQ_EN
  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_HANDLER = 1'b1;

  logic        r_state;
  logic [31:0] r_mepc;

  // No nesting: requests are only honoured in RUN, and never while the front end is stalled.
  assign w_mret_take = i_mret && (r_state == ST_HANDLER);
  assign w_irq_take  = i_irq && !i_stall && (r_state == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (!in_rst) begin
      r_state <= ST_RUN;
      r_mepc  <= 32'h0;
    end else if (w_mret_take) begin
      r_state <= ST_RUN;
    end else if (w_irq_take) begin
      r_state <= ST_HANDLER;
      // A branch resolving in the trap cycle is the true next instruction, so return there.
      r_mepc  <= i_br_taken ? i_br_target : r_pc;
    end
  end

  assign o_mepc    = r_mepc;
  assign o_irq_ack = in_rst && w_irq_take;
`else
  logic w_unused_irq;

  assign w_unused_irq = i_irq ^ i_mret;
  assign w_mret_take  = 1'b0;
  assign w_irq_take   = 1'b0;
  assign o_mepc       = 32'h0;
  assign o_irq_ack    = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = r_pc + 32'd4;
    w_flush  = 1'b0;
    w_hold   = 1'b0;
    if (w_mret_take) begin
      w_pc_nxt = o_mepc;
      w_flush  = 1'b1;
    end else if (w_irq_take) begin
      w_pc_nxt = TRAP_VEC;
      w_flush  = 1'b1;
    end else if (i_br_taken) begin
      w_pc_nxt = i_br_target;
      w_flush  = 1'b1;
    end else if (i_stall) begin
      w_hold   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!in_rst) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else begin
      if (!w_hold) begin
        r_pc <= w_pc_nxt;
      end
      // Any redirect drops the word currently being fetched and inserts a bubble.
      if (w_flush) begin
        r_ifid_pc    <= 32'h0;
        r_ifid_instr <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else if (!w_hold) begin
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= i_instr;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign o_pc         = r_pc;
  assign o_ifid_pc    = r_ifid_pc;
  assign o_ifid_instr = r_ifid_instr;
  assign o_ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expectations follow the FETCH_IRQ_EN build setting.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        irq = 1'b0;
  logic        mret = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        ack;
  logic [31:0] mepc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;

  int n_pass = 0;
  int n_total = 0;

  fetch_stage dut (
    .i_clk        (clk),
    .in_rst       (rst_n),
    .o_pc         (pc),
    .i_instr      (instr),
    .i_stall      (stall),
    .i_br_taken   (br),
    .i_br_target  (tgt),
    .i_irq        (irq),
    .i_mret       (mret),
    .o_irq_ack    (ack),
    .o_mepc       (mepc),
    .o_ifid_pc    (ifid_pc),
    .o_ifid_instr (ifid_instr),
    .o_ifid_valid (ifid_valid)
  );

  // Instruction memory: each word encodes its own address.
  assign instr = 32'hC000_0000 | pc;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] epc, input logic ev);
    chk({tag, ".ifid_pc"}, ifid_pc, ev ? epc : 32'h0);
    chk({tag, ".ifid_instr"}, ifid_instr, ev ? (32'hC000_0000 | epc) : 32'h0000_0013);
    chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, ev});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick;
    tick;
    chk("rst.pc", pc, 32'h0);
    chk_ifid("rst", 32'h0, 1'b0);
    chk("rst.mepc", mepc, 32'h0);
    chk("rst.ack", {31'b0, ack}, 32'h0);

    // Sequential fetch after release
    rst_n = 1'b1;
    chk("seq0.pc", pc, 32'h0);
    tick;
    chk("seq1.pc", pc, 32'h4);
    chk_ifid("seq1", 32'h0, 1'b1);
    tick;
    chk("seq2.pc", pc, 32'h8);
    chk_ifid("seq2", 32'h4, 1'b1);

    // Branch at pc=8 to 0x40: one bubble
    br = 1'b1; tgt = 32'h40;
    tick;
    br = 1'b0;
    chk("br.pc", pc, 32'h40);
    chk_ifid("br", 32'h0, 1'b0);
    tick;
    chk("br1.pc", pc, 32'h44);
    chk_ifid("br1", 32'h40, 1'b1);

    // Move to pc=12
    br = 1'b1; tgt = 32'h8;
    tick;
    br = 1'b0;
    chk("br8.pc", pc, 32'h8);
    tick;
    chk("at12.pc", pc, 32'hC);
    chk_ifid("at12", 32'h8, 1'b1);

`ifdef FETCH_IRQ_EN
    // Interrupt at pc=12
    irq = 1'b1;
    #1;
    chk("irq.ack_pre", {31'b0, ack}, 32'h1);
    tick;
    chk("irq.pc", pc, 32'h100);
    chk("irq.mepc", mepc, 32'hC);
    chk("irq.ack_hnd", {31'b0, ack}, 32'h0);
    chk_ifid("irq", 32'h0, 1'b0);
    tick;
    chk("hnd.pc", pc, 32'h104);
    chk_ifid("hnd", 32'h100, 1'b1);
    chk("hnd.mepc", mepc, 32'hC);
    chk("hnd.ack", {31'b0, ack}, 32'h0);

    // mret with irq still high: mret wins, trap follows once back in RUN
    mret = 1'b1;
    tick;
    mret = 1'b0;
    chk("mret.pc", pc, 32'hC);
    chk_ifid("mret", 32'h0, 1'b0);
    chk("mret.ack_next", {31'b0, ack}, 32'h1);
    tick;
    chk("retrap.pc", pc, 32'h100);
    chk("retrap.mepc", mepc, 32'hC);
    irq = 1'b0;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    chk("mret2.pc", pc, 32'hC);

    // Branch and interrupt in the same cycle
    br = 1'b1; tgt = 32'h80; irq = 1'b1;
    #1;
    chk("brirq.ack", {31'b0, ack}, 32'h1);
    tick;
    br = 1'b0; irq = 1'b0;
    chk("brirq.pc", pc, 32'h100);
    chk("brirq.mepc", mepc, 32'h80);
    chk_ifid("brirq", 32'h0, 1'b0);
    mret = 1'b1;
    tick;
    mret = 1'b0;
    chk("brirq_ret.pc", pc, 32'h80);
    tick;
`else
    // Interrupt path absent: irq and mret ignored
    irq = 1'b1;
    #1;
    chk("noirq.ack", {31'b0, ack}, 32'h0);
    tick;
    chk("noirq.pc", pc, 32'h10);
    chk_ifid("noirq", 32'hC, 1'b1);
    chk("noirq.mepc", mepc, 32'h0);
    mret = 1'b1;
    tick;
    mret = 1'b0;
    chk("nomret.pc", pc, 32'h14);
    chk_ifid("nomret", 32'h10, 1'b1);
    br = 1'b1; tgt = 32'h80;
    tick;
    br = 1'b0; irq = 1'b0;
    chk("nobrirq.pc", pc, 32'h80);
    chk("nobrirq.mepc", mepc, 32'h0);
    chk_ifid("nobrirq", 32'h0, 1'b0);
    tick;
`endif
    chk("pre_stall.pc", pc, 32'h84);
    chk_ifid("pre_stall", 32'h80, 1'b1);

    // Stall for three edges, irq raised mid-stall
    stall = 1'b1;
    tick;
    chk("stall1.pc", pc, 32'h84);
    chk_ifid("stall1", 32'h80, 1'b1);
    irq = 1'b1;
    #1;
    chk("stall.ack", {31'b0, ack}, 32'h0);
    tick;
    chk("stall2.pc", pc, 32'h84);
    chk_ifid("stall2", 32'h80, 1'b1);
    tick;
    chk("stall3.pc", pc, 32'h84);
    stall = 1'b0;
    #1;
`ifdef FETCH_IRQ_EN
    chk("unstall.ack", {31'b0, ack}, 32'h1);
    tick;
    irq = 1'b0;
    chk("unstall.pc", pc, 32'h100);
    chk("unstall.mepc", mepc, 32'h84);
    chk_ifid("unstall", 32'h0, 1'b0);
`else
    chk("unstall.ack", {31'b0, ack}, 32'h0);
    tick;
    irq = 1'b0;
    chk("unstall.pc", pc, 32'h88);
    chk_ifid("unstall", 32'h84, 1'b1);
`endif

    // Reset while (possibly) in the handler, then mret must be ignored
    rst_n = 1'b0;
    tick;
    chk("rst2.pc", pc, 32'h0);
    chk("rst2.mepc", mepc, 32'h0);
    chk_ifid("rst2", 32'h0, 1'b0);
    rst_n = 1'b1;
    mret = 1'b1;
    #1;
    chk("rst2.ack", {31'b0, ack}, 32'h0);
    tick;
    mret = 1'b0;
    chk("rst2_mret.pc", pc, 32'h4);
    chk_ifid("rst2_mret", 32'h0, 1'b1);
    chk("rst2_mret.mepc", mepc, 32'h0);

    // PC wrap-around
    br = 1'b1; tgt = 32'hFFFF_FFFC;
    tick;
    br = 1'b0;
    chk("wrap0.pc", pc, 32'hFFFF_FFFC);
    tick;
    chk("wrap1.pc", pc, 32'h0);
    chk_ifid("wrap1", 32'hFFFF_FFFC, 1'b1);

    // Branch overrides stall
    stall = 1'b1; br = 1'b1; tgt = 32'h200;
    tick;
    br = 1'b0;
    chk("brstall.pc", pc, 32'h200);
    chk_ifid("brstall", 32'h0, 1'b0);
    tick;
    chk("brstall_hold.pc", pc, 32'h200);
    stall = 1'b0;
    tick;
    chk("brstall_run.pc", pc, 32'h204);
    chk_ifid("brstall_run", 32'h200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
